vram_fetch_ctrl: RTL

//  Feeds the 16-bit pixel_row of the 800x600 VGA timing engine from text RAM + font ROM.

---
 rtl/vram_fetch_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vram_fetch_ctrl.sv
// vram_fetch_ctrl
//   Supplies the 16-bit glyph row for each 16-pixel character cell of an
//   800x600 VGA text display. Each cell needs two lookups: the character code
//   from the text RAM, then the glyph row from the font ROM. The text RAM is
//   single-ported and shared with a CPU, and display fetches always win.
//   pixel_row holds the cell being shifted out while next_row holds the
//   prefetched cell after it.
//
// Ports
//   CLK_VGA, resetn            pixel clock, asynchronous active-low reset
//   newData                    one-cycle pulse at h%16==15 inside the active area
//   end_of_line, end_of_frame  last cycle of line / frame from the VGA engine
//   line_number                scanline inside the current character row
//   pixel_row                  glyph row of the current cell
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   text RAM port (1-cycle read)
//   font_addr/font_data        font ROM port (1-cycle read)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata            CPU request, held until cpu_ready
//   cpu_ready                  request accepted this cycle
//   cpu_rvalid/cpu_rdata       read data, one cycle after an accepted read
module vram_fetch_ctrl #(
    parameter int COLS   = 50,
    parameter int ROWS   = 30,
    parameter int FONT_H = 20,
    parameter int ADDR_W = 11
) (
    input  logic              CLK_VGA,
    input  logic              resetn,
    input  logic              newData,
    input  logic              end_of_line,
    input  logic              end_of_frame,
    input  logic [4:0]        line_number,
    output logic [15:0]       pixel_row,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [12:0]       font_addr,
    input  logic [15:0]       font_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata
);

    // RD: display owns the RAM; FA: char code on ram_rdata drives the font ROM;
    // LD: glyph row arrives. W1/W2 delay the pixel_row swap to h%16==2.
    typedef enum logic [2:0] {IDLE, RD, FA, LD, W1, W2} state_t;

    state_t            state_q;
    logic [15:0]       pixel_row_q;
    logic [15:0]       next_row_q;
    logic [5:0]        fcol_q;        // column currently being fetched
    logic [5:0]        crow_q;        // character row, saturates at ROWS
    logic [5:0]        crow_d;
    logic              tgt_pix_q;     // line-start first fetch lands in pixel_row
    logic              cpu_rvalid_q;
    logic              act_q;         // keeps the CPU off the RAM while in reset
    logic              disp_rd;
    logic              row_ok;
    logic [ADDR_W-1:0] char_addr;

    assign disp_rd   = (state_q == RD);
    assign row_ok    = int'(crow_q) < ROWS;
    assign char_addr = ADDR_W'(int'(crow_q) * COLS + int'(fcol_q));

    assign cpu_ready  = cpu_req & act_q & ~disp_rd;
    assign ram_en     = disp_rd | cpu_ready;
    assign ram_we     = cpu_ready & cpu_we;
    assign ram_addr   = disp_rd ? char_addr : cpu_addr;
    assign ram_wdata  = cpu_wdata;
    assign cpu_rdata  = ram_rdata;
    assign cpu_rvalid = cpu_rvalid_q;
    assign pixel_row  = pixel_row_q;

    // line_number is stable for the whole fetch, so it can feed the ROM live.
    assign font_addr = {ram_rdata, line_number};

    // Row counter value for the line that starts after end_of_line.
    always_comb begin
        crow_d = crow_q;
        if (end_of_frame) begin
            crow_d = '0;
        end else if (line_number == 5'(FONT_H - 1) && int'(crow_q) < ROWS) begin
            crow_d = crow_q + 6'd1;
        end
    end

    always_ff @(posedge CLK_VGA or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            pixel_row_q  <= '0;
            next_row_q   <= '0;
            fcol_q       <= '0;
            crow_q       <= '0;
            tgt_pix_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            act_q        <= 1'b0;
        end else begin
            act_q        <= 1'b1;
            cpu_rvalid_q <= cpu_ready & ~cpu_we;
            if (end_of_line) begin
                // Line start overrides whatever fetch was in flight.
                crow_q    <= crow_d;
                fcol_q    <= '0;
                tgt_pix_q <= 1'b1;
                if (int'(crow_d) < ROWS) begin
                    state_q <= RD;
                end else begin
                    // Below the text area: blank cells, no RAM traffic.
                    pixel_row_q <= '0;
                    next_row_q  <= '0;
                    fcol_q      <= 6'd1;
                    tgt_pix_q   <= 1'b0;
                    state_q     <= IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: if (newData) state_q <= W1;
                    W1:   state_q <= W2;
                    W2: begin
                        pixel_row_q <= next_row_q;
                        if (int'(fcol_q) + 1 < COLS && row_ok) begin
                            fcol_q  <= fcol_q + 6'd1;
                            state_q <= RD;
                        end else begin
                            next_row_q <= '0;
                            state_q    <= IDLE;
                        end
                    end
                    RD:   state_q <= FA;
                    FA:   state_q <= LD;
                    LD: begin
                        if (tgt_pix_q) begin
                            // Column 0 done; chain straight into column 1.
                            pixel_row_q <= font_data;
                            tgt_pix_q   <= 1'b0;
                            fcol_q      <= 6'd1;
                            state_q     <= RD;
                        end else begin
                            next_row_q <= font_data;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
